// File: rtl/muldiv_seq_pkg.sv
// RV32M alucode constants shared with the ALU, plus small decode helpers
// used by the sequential multiply/divide unit.
package muldiv_seq_pkg;

    localparam logic [4:0] ALU_MUL    = 5'h10;
    localparam logic [4:0] ALU_MULH   = 5'h11;
    localparam logic [4:0] ALU_MULHSU = 5'h12;
    localparam logic [4:0] ALU_MULHU  = 5'h13;
    localparam logic [4:0] ALU_DIV    = 5'h14;
    localparam logic [4:0] ALU_DIVU   = 5'h15;
    localparam logic [4:0] ALU_REM    = 5'h16;
    localparam logic [4:0] ALU_REMU   = 5'h17;

    // Codes 0x10..0x17 are the M-extension; anything else yields 0.
    function automatic logic is_m_op(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

    function automatic logic is_mul_op(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return op[1];
    endfunction

    function automatic logic x_is_signed(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic y_is_signed(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide: shift-add multiply, restoring divide,
// one bit per cycle on unsigned magnitudes with a final sign-fix step.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  alucode,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        kill,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  op_reg;
    logic        x_neg_reg, y_neg_reg;
    logic [4:0]  cnt_reg;
    logic [63:0] acc_reg;
    logic [32:0] rem_reg;
    logic [31:0] b_reg;
    logic [31:0] result_reg;
    logic        resp_valid_reg, busy_reg;

    logic        accept;
    logic        x_neg, y_neg;
    logic [31:0] x_mag, y_mag;
    logic        special;
    logic [31:0] special_result;

    assign req_ready  = rst_n && (state_reg == S_IDLE);
    assign accept     = req_valid && req_ready && !kill;
    assign resp_valid = resp_valid_reg;
    assign result     = result_reg;
    assign busy       = busy_reg;

    assign x_neg = x_is_signed(alucode) && x[31];
    assign y_neg = y_is_signed(alucode) && y[31];
    assign x_mag = x_neg ? -x : x;
    assign y_mag = y_neg ? -y : y;

    // Cases whose answer is fixed by the ISA skip the iteration entirely.
    always_comb begin
        special        = 1'b0;
        special_result = 32'd0;
        if (!is_m_op(alucode)) begin
            special = 1'b1;
        end else if (!is_mul_op(alucode) && (y == 32'd0)) begin
            special        = 1'b1;
            special_result = is_rem_op(alucode) ? x : 32'hFFFF_FFFF;
        end else if (((alucode == ALU_DIV) || (alucode == ALU_REM)) &&
                     (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) begin
            special        = 1'b1;
            special_result = (alucode == ALU_DIV) ? 32'h8000_0000 : 32'd0;
        end
    end

    // Multiply: high half accumulates, low half holds the multiplier and
    // shifts right so its LSB selects the next add.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, b_reg} : 33'd0);
    assign mul_next = {mul_sum, acc_reg[31:1]};

    // Divide: low half holds the dividend, which shifts out MSB first while
    // quotient bits shift in at the bottom.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [32:0] div_rem_next;
    logic [63:0] div_q_next;
    assign div_shift    = {rem_reg[31:0], acc_reg[31]};
    assign div_diff     = {1'b0, div_shift} - {2'b00, b_reg};
    assign div_ge       = !div_diff[33];
    assign div_rem_next = div_ge ? div_diff[32:0] : div_shift;
    assign div_q_next   = {32'd0, acc_reg[30:0], div_ge};

    logic        neg_out;
    logic [63:0] prod_fixed;
    logic [31:0] quot_fixed, rem_fixed, fix_result;
    assign neg_out    = x_neg_reg ^ y_neg_reg;
    assign prod_fixed = neg_out ? -acc_reg : acc_reg;
    assign quot_fixed = neg_out ? -acc_reg[31:0] : acc_reg[31:0];
    assign rem_fixed  = x_neg_reg ? -rem_reg[31:0] : rem_reg[31:0];

    always_comb begin
        if (op_reg == ALU_MUL)
            fix_result = prod_fixed[31:0];
        else if (is_mul_op(op_reg))
            fix_result = prod_fixed[63:32];
        else if (is_rem_op(op_reg))
            fix_result = rem_fixed;
        else
            fix_result = quot_fixed;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = special ? S_DONE : S_CALC;
            S_CALC: if (cnt_reg == 5'd31) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (kill) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            op_reg         <= 5'd0;
            x_neg_reg      <= 1'b0;
            y_neg_reg      <= 1'b0;
            cnt_reg        <= 5'd0;
            acc_reg        <= 64'd0;
            rem_reg        <= 33'd0;
            b_reg          <= 32'd0;
            result_reg     <= 32'd0;
            resp_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            busy_reg       <= (state_next != S_IDLE);
            resp_valid_reg <= (state_next == S_DONE);
            case (state_reg)
                S_IDLE: if (accept) begin
                    op_reg    <= alucode;
                    x_neg_reg <= x_neg;
                    y_neg_reg <= y_neg;
                    cnt_reg   <= 5'd0;
                    rem_reg   <= 33'd0;
                    acc_reg   <= {32'd0, is_mul_op(alucode) ? y_mag : x_mag};
                    b_reg     <= is_mul_op(alucode) ? x_mag : y_mag;
                    if (special) result_reg <= special_result;
                end
                S_CALC: begin
                    cnt_reg <= cnt_reg + 5'd1;
                    if (is_mul_op(op_reg)) begin
                        acc_reg <= mul_next;
                    end else begin
                        acc_reg <= div_q_next;
                        rem_reg <= div_rem_next;
                    end
                end
                S_FIX: if (!kill) result_reg <= fix_result;
                default: ;
            endcase
        end
    end

endmodule
